// File: rtl/trap_ctrl.sv
// trap_ctrl: precise-trap sequencer. Picks one event from the exception, interrupt
// and eret sources, writes EPC/CAUSE, flushes the pipe, then redirects fetch.
module trap_ctrl #(
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] IRQ_CAUSE    = 32'h8000_000B
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_if_valid,
   input  logic [31:0] exc_if_pc,
   input  logic [31:0] exc_if_cause,
   input  logic        exc_id_valid,
   input  logic [31:0] exc_id_pc,
   input  logic [31:0] exc_id_cause,
   input  logic        exc_mem_valid,
   input  logic [31:0] exc_mem_pc,
   input  logic [31:0] exc_mem_cause,
   input  logic        irq,
   input  logic [31:0] irq_pc,
   input  logic        eret_req,
   input  logic [31:0] epc_ro,
   input  logic        redirect_ready,
   output logic        trap_set,
   output logic [31:0] epc_w,
   output logic [31:0] cause_w,
   output logic        flush_event,
   output logic        flush_pipe,
   output logic        stall_front,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        in_handler
);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

   // Counter counts down to zero, so the load value is one less than the flush length.
   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        in_handler_q, eret_q;
   logic        trap_set_q, flush_event_q;
   logic [31:0] epc_q, cause_q, rpc_q;

   logic        take_trap, take_eret, hs;
   logic [31:0] sel_pc, sel_cause;

   // Source selection: only evaluated in IDLE, fixed priority mem > id > if > irq > eret.
   always_comb begin
      take_trap = 1'b0;
      take_eret = 1'b0;
      sel_pc    = '0;
      sel_cause = '0;
      if (state_q == IDLE) begin
         if (exc_mem_valid) begin
            take_trap = 1'b1; sel_pc = exc_mem_pc; sel_cause = exc_mem_cause;
         end else if (exc_id_valid) begin
            take_trap = 1'b1; sel_pc = exc_id_pc;  sel_cause = exc_id_cause;
         end else if (exc_if_valid) begin
            take_trap = 1'b1; sel_pc = exc_if_pc;  sel_cause = exc_if_cause;
         end else if (irq && !in_handler_q) begin
            take_trap = 1'b1; sel_pc = irq_pc;     sel_cause = IRQ_CAUSE;
         end else if (eret_req) begin
            take_eret = 1'b1;
         end
      end
   end

   assign hs = (state_q == REDIR) && redirect_ready;

   // State register and flush counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: IDLE -> FLUSH on any selected event, FLUSH -> REDIR at count 0,
   // REDIR -> IDLE on the fetch handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (take_trap || take_eret) begin
               state_d = FLUSH;
               cnt_d   = CNT_INIT;
            end
         end
         FLUSH: begin
            if (cnt_q == 4'd0) state_d = REDIR;
            else               cnt_d   = cnt_q - 4'd1;
         end
         REDIR: begin
            if (redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // CSR write data, one-shot strobes, redirect target and handler flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_set_q    <= 1'b0;
         flush_event_q <= 1'b0;
         epc_q         <= '0;
         cause_q       <= '0;
         rpc_q         <= '0;
         in_handler_q  <= 1'b0;
         eret_q        <= 1'b0;
      end else begin
         trap_set_q    <= take_trap;
         flush_event_q <= take_trap | take_eret;
         if (take_trap) begin
            epc_q        <= sel_pc;
            cause_q      <= sel_cause;
            rpc_q        <= TRAP_VECTOR;
            in_handler_q <= 1'b1;
            eret_q       <= 1'b0;
         end else if (take_eret) begin
            rpc_q  <= epc_ro;
            eret_q <= 1'b1;
         end
         // Returning from the handler only completes once fetch takes the EPC.
         if (hs && eret_q) begin
            in_handler_q <= 1'b0;
            eret_q       <= 1'b0;
         end
      end
   end

   // Pipeline control decoded from state.
   always_comb begin
      flush_pipe     = (state_q == FLUSH);
      stall_front    = (state_q == FLUSH) || (state_q == REDIR);
      redirect_valid = (state_q == REDIR);
   end

   assign trap_set    = trap_set_q;
   assign flush_event = flush_event_q;
   assign epc_w       = epc_q;
   assign cause_w     = cause_q;
   assign redirect_pc = rpc_q;
   assign in_handler  = in_handler_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: scoreboard of expected trap/eret events, checked when the
// DUT pulses flush_event and again at the redirect handshake.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        exc_if_valid = 0, exc_id_valid = 0, exc_mem_valid = 0;
   logic [31:0] exc_if_pc = 0, exc_if_cause = 0, exc_id_pc = 0, exc_id_cause = 0;
   logic [31:0] exc_mem_pc = 0, exc_mem_cause = 0, irq_pc = 0, epc_ro = 0;
   logic        irq = 0, eret_req = 0, redirect_ready = 1;

   logic        trap_set, flush_event, flush_pipe, stall_front, redirect_valid, in_handler;
   logic [31:0] epc_w, cause_w, redirect_pc;

   // flush-length variants
   logic        a_ts, a_fe, a_fp, a_sf, a_rv, a_ih;
   logic [31:0] a_epc, a_cause, a_rpc;
   logic        b_ts, b_fe, b_fp, b_sf, b_rv, b_ih;
   logic [31:0] b_epc, b_cause, b_rpc;

   always #5 clk = ~clk;

   trap_ctrl dut (
      .clk(clk), .rst(rst),
      .exc_if_valid(exc_if_valid), .exc_if_pc(exc_if_pc), .exc_if_cause(exc_if_cause),
      .exc_id_valid(exc_id_valid), .exc_id_pc(exc_id_pc), .exc_id_cause(exc_id_cause),
      .exc_mem_valid(exc_mem_valid), .exc_mem_pc(exc_mem_pc), .exc_mem_cause(exc_mem_cause),
      .irq(irq), .irq_pc(irq_pc), .eret_req(eret_req), .epc_ro(epc_ro),
      .redirect_ready(redirect_ready),
      .trap_set(trap_set), .epc_w(epc_w), .cause_w(cause_w), .flush_event(flush_event),
      .flush_pipe(flush_pipe), .stall_front(stall_front), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .in_handler(in_handler));

   trap_ctrl #(.FLUSH_CYCLES(1)) dut_f1 (
      .clk(clk), .rst(rst),
      .exc_if_valid(exc_if_valid), .exc_if_pc(exc_if_pc), .exc_if_cause(exc_if_cause),
      .exc_id_valid(exc_id_valid), .exc_id_pc(exc_id_pc), .exc_id_cause(exc_id_cause),
      .exc_mem_valid(exc_mem_valid), .exc_mem_pc(exc_mem_pc), .exc_mem_cause(exc_mem_cause),
      .irq(irq), .irq_pc(irq_pc), .eret_req(eret_req), .epc_ro(epc_ro),
      .redirect_ready(redirect_ready),
      .trap_set(a_ts), .epc_w(a_epc), .cause_w(a_cause), .flush_event(a_fe),
      .flush_pipe(a_fp), .stall_front(a_sf), .redirect_valid(a_rv),
      .redirect_pc(a_rpc), .in_handler(a_ih));

   trap_ctrl #(.FLUSH_CYCLES(15)) dut_f15 (
      .clk(clk), .rst(rst),
      .exc_if_valid(exc_if_valid), .exc_if_pc(exc_if_pc), .exc_if_cause(exc_if_cause),
      .exc_id_valid(exc_id_valid), .exc_id_pc(exc_id_pc), .exc_id_cause(exc_id_cause),
      .exc_mem_valid(exc_mem_valid), .exc_mem_pc(exc_mem_pc), .exc_mem_cause(exc_mem_cause),
      .irq(irq), .irq_pc(irq_pc), .eret_req(eret_req), .epc_ro(epc_ro),
      .redirect_ready(redirect_ready),
      .trap_set(b_ts), .epc_w(b_epc), .cause_w(b_cause), .flush_event(b_fe),
      .flush_pipe(b_fp), .stall_front(b_sf), .redirect_valid(b_rv),
      .redirect_pc(b_rpc), .in_handler(b_ih));

   typedef struct packed {
      logic        is_trap;
      logic [31:0] epc;
      logic [31:0] cause;
      logic [31:0] rpc;
   } exp_t;

   exp_t sb[$];
   exp_t cur = '0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard monitor: every flush_event must match the oldest expected event.
   always @(negedge clk) begin
      if (flush_event) begin
         if (sb.size() == 0) begin
            chk("unexpected_flush_event", 32'd1, 32'd0);
         end else begin
            cur = sb.pop_front();
            chk("trap_set", {31'd0, trap_set}, {31'd0, cur.is_trap});
            if (cur.is_trap) begin
               chk("epc_w", epc_w, cur.epc);
               chk("cause_w", cause_w, cur.cause);
            end
         end
      end else if (trap_set) begin
         chk("stray_trap_set", 32'd1, 32'd0);
      end
      if (redirect_valid && redirect_ready)
         chk("redirect_pc", redirect_pc, cur.rpc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic push(input logic t, input logic [31:0] e, input logic [31:0] c,
                       input logic [31:0] r);
      exp_t x;
      x.is_trap = t; x.epc = e; x.cause = c; x.rpc = r;
      sb.push_back(x);
   endtask

   // stage: 0=IF 1=ID 2=MEM. Request is held across exactly one sampling edge.
   task automatic issue_exc(input int stage, input logic [31:0] pc, input logic [31:0] cause);
      @(posedge clk); #1;
      case (stage)
         0: begin exc_if_valid = 1;  exc_if_pc = pc;  exc_if_cause = cause;  end
         1: begin exc_id_valid = 1;  exc_id_pc = pc;  exc_id_cause = cause;  end
         default: begin exc_mem_valid = 1; exc_mem_pc = pc; exc_mem_cause = cause; end
      endcase
      @(posedge clk); #1;
      exc_if_valid = 0; exc_id_valid = 0; exc_mem_valid = 0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin @(negedge clk); n++; end while (stall_front && n < 60);
      if (stall_front) chk(tag, 32'd1, 32'd0);
   endtask

   initial begin
      logic [2:0] ctl_exp [4];
      int w0, w1, w15;
      ctl_exp[0] = 3'b101; ctl_exp[1] = 3'b101; ctl_exp[2] = 3'b011; ctl_exp[3] = 3'b000;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", {28'd0, trap_set, flush_event, in_handler, redirect_valid}, 32'd0);
      chk("rst_pipe", {30'd0, flush_pipe, stall_front}, 32'd0);
      chk("rst_epc", epc_w, 32'd0);
      chk("rst_cause", cause_w, 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      @(posedge clk); #1 rst = 0;

      // single ID exception, exact cycle timeline
      push(1, 32'h40, 32'd2, 32'h100);
      issue_exc(1, 32'h40, 32'd2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("timeline_T%0d", k + 1), {29'd0, flush_pipe, redirect_valid, stall_front},
             {29'd0, ctl_exp[k]});
      end
      chk("in_handler_after_trap", {31'd0, in_handler}, 32'd1);

      // all three stages at once: MEM wins, single trap_set
      @(posedge clk); #1;
      exc_if_valid = 1;  exc_if_pc = 32'h48;  exc_if_cause = 32'd1;
      exc_id_valid = 1;  exc_id_pc = 32'h44;  exc_id_cause = 32'd2;
      exc_mem_valid = 1; exc_mem_pc = 32'h3C; exc_mem_cause = 32'd4;
      push(1, 32'h3C, 32'd4, 32'h100);
      @(posedge clk); #1;
      exc_if_valid = 0; exc_id_valid = 0; exc_mem_valid = 0;
      wait_idle("timeout_prio");

      // irq masked in handler, then eret, then the held irq is taken
      @(posedge clk); #1 irq = 1; irq_pc = 32'h200;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("irq_masked", {31'd0, stall_front}, 32'd0);
      end
      push(0, 32'h0, 32'h0, 32'h3C);
      push(1, 32'h200, 32'h8000_000B, 32'h100);
      @(posedge clk); #1 eret_req = 1; epc_ro = 32'h3C;
      @(posedge clk); #1 eret_req = 0;
      wait_idle("timeout_eret");
      chk("in_handler_after_eret", {31'd0, in_handler}, 32'd0);
      @(posedge clk); #1 irq = 0;
      wait_idle("timeout_irq");
      chk("in_handler_after_irq", {31'd0, in_handler}, 32'd1);

      // redirect back-pressure; an exception arriving in REDIRECT is ignored
      redirect_ready = 0;
      push(1, 32'h80, 32'd5, 32'h100);
      issue_exc(2, 32'h80, 32'd5);
      begin
         int n = 0;
         while (!redirect_valid && n < 40) begin @(negedge clk); n++; end
         if (!redirect_valid) chk("timeout_rv", 32'd1, 32'd0);
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("hold_rv", {31'd0, redirect_valid}, 32'd1);
         chk("hold_rpc", redirect_pc, 32'h100);
         @(posedge clk); #1;
         exc_mem_valid = 1; exc_mem_pc = 32'h90; exc_mem_cause = 32'd7;
      end
      exc_mem_valid = 0; redirect_ready = 1;
      wait_idle("timeout_bp");
      repeat (2) @(negedge clk);
      chk("no_late_trap", {31'd0, stall_front}, 32'd0);

      // reset in the middle of FLUSH
      push(1, 32'h60, 32'd1, 32'h100);
      issue_exc(0, 32'h60, 32'd1);
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_ctl", {26'd0, trap_set, flush_event, flush_pipe, stall_front, redirect_valid,
          in_handler}, 32'd0);
      chk("midrst_epc", epc_w, 32'd0);
      chk("midrst_rpc", redirect_pc, 32'd0);
      @(posedge clk); #1 rst = 0;
      push(1, 32'h70, 32'd3, 32'h100);
      issue_exc(1, 32'h70, 32'd3);
      wait_idle("timeout_postrst");
      chk("in_handler_postrst", {31'd0, in_handler}, 32'd1);

      // flush length for FLUSH_CYCLES = 2 / 1 / 15
      @(posedge clk); #1 rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      push(1, 32'hA0, 32'd6, 32'h100);
      issue_exc(2, 32'hA0, 32'd6);
      w0 = 0; w1 = 0; w15 = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         w0 += int'(flush_pipe); w1 += int'(a_fp); w15 += int'(b_fp);
      end
      chk("flush_width_2", 32'(w0), 32'd2);
      chk("flush_width_1", 32'(w1), 32'd1);
      chk("flush_width_15", 32'(w15), 32'd15);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
